// File: rtl/morse_char_seq.sv
// Morse character sequencer: accepts a character code, issues one symbol request per element
// to the LED FSM and enforces letter/word gaps. Define MORSE_DIGITS_EN to add digits 0-9 (codes 27-36).
module morse_char_seq #(
    parameter int LETTER_GAP = 1,
    parameter int WORD_GAP   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       char_valid_i,
    input  logic [5:0] char_code_i,
    output logic       char_ready_o,
    output logic       char_err_o,
    output logic       sym_strt_o,
    output logic       symbol_o,
    input  logic       sym_done_i,
    output logic       busy_o
);

    localparam int GAP_MAX = (LETTER_GAP > WORD_GAP) ? LETTER_GAP : WORD_GAP;
    localparam int GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
    localparam logic [5:0] SPACE_CODE = 6'd26;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       pat_q, pat_d;
    logic [2:0]       elem_q, elem_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             sym_strt_q, sym_strt_d;
    logic             char_err_q, char_err_d;
    logic [7:0]       rom_s;

    // Returns {len[2:0], pat[4:0]}, pattern left-aligned; len 0 marks a code with no pattern.
    function automatic logic [7:0] rom_lookup(input logic [5:0] code);
        case (code)
            6'd0:  rom_lookup = {3'd2, 5'b01000};
            6'd1:  rom_lookup = {3'd4, 5'b10000};
            6'd2:  rom_lookup = {3'd4, 5'b10100};
            6'd3:  rom_lookup = {3'd3, 5'b10000};
            6'd4:  rom_lookup = {3'd1, 5'b00000};
            6'd5:  rom_lookup = {3'd4, 5'b00100};
            6'd6:  rom_lookup = {3'd3, 5'b11000};
            6'd7:  rom_lookup = {3'd4, 5'b00000};
            6'd8:  rom_lookup = {3'd2, 5'b00000};
            6'd9:  rom_lookup = {3'd4, 5'b01110};
            6'd10: rom_lookup = {3'd3, 5'b10100};
            6'd11: rom_lookup = {3'd4, 5'b01000};
            6'd12: rom_lookup = {3'd2, 5'b11000};
            6'd13: rom_lookup = {3'd2, 5'b10000};
            6'd14: rom_lookup = {3'd3, 5'b11100};
            6'd15: rom_lookup = {3'd4, 5'b01100};
            6'd16: rom_lookup = {3'd4, 5'b11010};
            6'd17: rom_lookup = {3'd3, 5'b01000};
            6'd18: rom_lookup = {3'd3, 5'b00000};
            6'd19: rom_lookup = {3'd1, 5'b10000};
            6'd20: rom_lookup = {3'd3, 5'b00100};
            6'd21: rom_lookup = {3'd4, 5'b00010};
            6'd22: rom_lookup = {3'd3, 5'b01100};
            6'd23: rom_lookup = {3'd4, 5'b10010};
            6'd24: rom_lookup = {3'd4, 5'b10110};
            6'd25: rom_lookup = {3'd4, 5'b11000};
`ifdef MORSE_DIGITS_EN
            6'd27: rom_lookup = {3'd5, 5'b11111};
            6'd28: rom_lookup = {3'd5, 5'b01111};
            6'd29: rom_lookup = {3'd5, 5'b00111};
            6'd30: rom_lookup = {3'd5, 5'b00011};
            6'd31: rom_lookup = {3'd5, 5'b00001};
            6'd32: rom_lookup = {3'd5, 5'b00000};
            6'd33: rom_lookup = {3'd5, 5'b10000};
            6'd34: rom_lookup = {3'd5, 5'b11000};
            6'd35: rom_lookup = {3'd5, 5'b11100};
            6'd36: rom_lookup = {3'd5, 5'b11110};
`endif
            default: rom_lookup = 8'd0;
        endcase
    endfunction

    assign rom_s = rom_lookup(char_code_i);

    // Next-state and output-register logic for the sequencer.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        elem_d     = elem_q;
        gap_d      = gap_q;
        sym_strt_d = 1'b0;
        char_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!char_valid_i) begin
                    state_d = S_IDLE;
                end else if (char_code_i == SPACE_CODE) begin
                    gap_d   = GAP_W'(WORD_GAP - 1);
                    state_d = S_GAP;
                end else if (rom_s[7:5] != 3'd0) begin
                    pat_d      = rom_s[4:0];
                    elem_d     = rom_s[7:5];
                    sym_strt_d = 1'b1;
                    state_d    = S_ISSUE;
                end else begin
                    char_err_d = 1'b1;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (sym_done_i) begin
                    pat_d  = {pat_q[3:0], 1'b0};
                    elem_d = elem_q - 3'd1;
                    // elem_q still holds the pre-decrement count here
                    if (elem_q != 3'd1) begin
                        sym_strt_d = 1'b1;
                        state_d    = S_ISSUE;
                    end else begin
                        gap_d   = GAP_W'(LETTER_GAP - 1);
                        state_d = S_GAP;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GAP: begin
                if (gap_q == {GAP_W{1'b0}}) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight letter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pat_q      <= 5'd0;
            elem_q     <= 3'd0;
            gap_q      <= {GAP_W{1'b0}};
            sym_strt_q <= 1'b0;
            char_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            elem_q     <= elem_d;
            gap_q      <= gap_d;
            sym_strt_q <= sym_strt_d;
            char_err_q <= char_err_d;
        end
    end

    assign sym_strt_o   = sym_strt_q;
    assign symbol_o     = pat_q[4];
    assign char_err_o   = char_err_q;
    assign busy_o       = (state_q != S_IDLE);
    assign char_ready_o = (state_q == S_IDLE) && !reset;

endmodule

// File: tb/tb_morse_char_seq.sv
// Directed bench for morse_char_seq with a simple LED FSM responder (done 2 cycles after a dot
// request, 4 after a dash). Expected cycle offsets are hand-derived from the timing rules.
module tb_morse_char_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       char_valid_i = 1'b0;
    logic [5:0] char_code_i = 6'd0;
    logic       sym_done_i = 1'b0;
    logic       char_ready_o, char_err_o, sym_strt_o, symbol_o, busy_o;

    morse_char_seq dut (
        .clock        (clock),
        .reset        (reset),
        .char_valid_i (char_valid_i),
        .char_code_i  (char_code_i),
        .char_ready_o (char_ready_o),
        .char_err_o   (char_err_o),
        .sym_strt_o   (sym_strt_o),
        .symbol_o     (symbol_o),
        .sym_done_i   (sym_done_i),
        .busy_o       (busy_o)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int strt_cyc[$];
    int strt_sym[$];
    int done_cyc[$];
    int err_cyc[$];
    int ready_rise = -1;
    int ready_low  = 0;
    bit prev_ready = 1'b0;
    int done_at    = -1;

    // LED FSM responder and event logger, evaluated mid-cycle
    always @(negedge clock) begin
        sym_done_i = (done_at == cyc);
        if (sym_done_i) begin
            done_cyc.push_back(cyc);
            done_at = -1;
        end
        if (sym_strt_o) begin
            strt_cyc.push_back(cyc);
            strt_sym.push_back(int'(symbol_o));
            done_at = cyc + (symbol_o ? 4 : 2);
        end
        if (char_err_o) err_cyc.push_back(cyc);
        if (char_ready_o && !prev_ready) ready_rise = cyc;
        if (!char_ready_o) ready_low++;
        prev_ready = char_ready_o;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_log();
        strt_cyc.delete();
        strt_sym.delete();
        done_cyc.delete();
        err_cyc.delete();
        ready_rise = -1;
        ready_low  = 0;
    endtask

    task automatic send(input logic [5:0] code, output int acc);
        int guard = 0;
        while (!char_ready_o && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check_val("send_ready", int'(char_ready_o), 1);
        char_valid_i = 1'b1;
        char_code_i  = code;
        acc = cyc;
        @(negedge clock);
        char_valid_i = 1'b0;
    endtask

    task automatic settle();
        int guard = 0;
        while (!(char_ready_o && !busy_o && done_at == -1) && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        check_val("settle_timeout", int'(guard < 300), 1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a2, a3;

        // reset values
        repeat (2) @(negedge clock);
        check_val("rst_ready", int'(char_ready_o), 0);
        check_val("rst_busy", int'(busy_o), 0);
        check_val("rst_strt", int'(sym_strt_o), 0);
        check_val("rst_symbol", int'(symbol_o), 0);
        check_val("rst_err", int'(char_err_o), 0);
        reset = 1'b0;
        #1;
        check_val("post_rst_ready", int'(char_ready_o), 1);
        @(negedge clock);

        // E: single dot
        clear_log();
        send(6'd4, a);
        settle();
        check_val("E_count", strt_cyc.size(), 1);
        check_val("E_strt_lat", qat(strt_cyc, 0) - a, 1);
        check_val("E_symbol", qat(strt_sym, 0), 0);
        check_val("E_done", qat(done_cyc, 0) - a, 3);
        check_val("E_ready", ready_rise - a, 5);

        // A: dot-dash
        clear_log();
        send(6'd0, a);
        settle();
        check_val("A_count", strt_cyc.size(), 2);
        check_val("A_sym0", qat(strt_sym, 0), 0);
        check_val("A_sym1", qat(strt_sym, 1), 1);
        check_val("A_elem_gap", qat(strt_cyc, 1) - qat(done_cyc, 0), 1);
        check_val("A_strt1", qat(strt_cyc, 1) - a, 4);
        check_val("A_ready", ready_rise - a, 10);

        // T, space, T: word gap
        clear_log();
        send(6'd19, a);
        send(6'd26, a2);
        send(6'd19, a3);
        settle();
        check_val("W_count", strt_cyc.size(), 2);
        check_val("W_sym1", qat(strt_sym, 1), 1);
        check_val("W_letter_gap", a2 - qat(done_cyc, 0), 2);
        check_val("W_space_len", a3 - a2, 4);
        check_val("W_word_gap", qat(strt_cyc, 1) - qat(done_cyc, 0), 7);

        // invalid code
        clear_log();
        send(6'd40, a);
        repeat (4) @(negedge clock);
        check_val("I_err_count", err_cyc.size(), 1);
        check_val("I_err_lat", qat(err_cyc, 0) - a, 1);
        check_val("I_no_strt", strt_cyc.size(), 0);
        check_val("I_ready_low", ready_low, 0);
        check_val("I_busy", int'(busy_o), 0);

        // Z: dash dash dot dot (last letter code)
        clear_log();
        send(6'd25, a);
        settle();
        check_val("Z_count", strt_cyc.size(), 4);
        check_val("Z_sym0", qat(strt_sym, 0), 1);
        check_val("Z_sym1", qat(strt_sym, 1), 1);
        check_val("Z_sym2", qat(strt_sym, 2), 0);
        check_val("Z_sym3", qat(strt_sym, 3), 0);

        // reset during WAIT of the second element of O
        clear_log();
        send(6'd14, a);
        while (cyc < a + 8) @(negedge clock);
        check_val("O_pre_rst_busy", int'(busy_o), 1);
        reset = 1'b1;
        #1;
        check_val("O_rst_ready", int'(char_ready_o), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_val("O_rst_busy", int'(busy_o), 0);
        check_val("O_rst_ready1", int'(char_ready_o), 1);
        repeat (8) @(negedge clock);
        check_val("O_strt_count", strt_cyc.size(), 2);
        check_val("O_late_done", qat(done_cyc, 1) - a, 10);
        check_val("O_idle", int'(busy_o), 0);

        // digit 0
        clear_log();
        send(6'd27, a);
        settle();
`ifdef MORSE_DIGITS_EN
        check_val("D_count", strt_cyc.size(), 5);
        for (int i = 0; i < 5; i++) check_val("D_sym", qat(strt_sym, i), 1);
        check_val("D_no_err", err_cyc.size(), 0);
`else
        check_val("D_err_count", err_cyc.size(), 1);
        check_val("D_err_lat", qat(err_cyc, 0) - a, 1);
        check_val("D_no_strt", strt_cyc.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
